// File: rtl/scr1_csr_pkg.sv
// Shared definitions for the scr1 CSR sequencer.
// Contents: CSR op encodings, sequencer FSM state type, the addresses of the
// 16 machine-mode CSRs implemented by the register file, and address
// classification helpers (mapped / read-only ID register).
package scr1_csr_pkg;

  // Request op encodings (funct3[1:0] of CSRRW/CSRRS/CSRRC)
  localparam logic [1:0] CsrOpRsv = 2'b00;
  localparam logic [1:0] CsrOpRw  = 2'b01;
  localparam logic [1:0] CsrOpRs  = 2'b10;
  localparam logic [1:0] CsrOpRc  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10,
    StResp  = 2'b11
  } csr_state_e;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMcounten  = 12'h306;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMvendorid = 12'hF11;
  localparam logic [11:0] CsrMarchid   = 12'hF12;
  localparam logic [11:0] CsrMimpid    = 12'hF13;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  function automatic logic csr_is_mapped(input logic [11:0] addr);
    logic hit;
    case (addr)
      CsrMstatus, CsrMisa, CsrMie, CsrMtvec, CsrMcounten,
      CsrMepc, CsrMcause, CsrMip,
      CsrMcycle, CsrMinstret, CsrMcycleh, CsrMinstreth,
      CsrMvendorid, CsrMarchid, CsrMimpid, CsrMhartid: hit = 1'b1;
      default:                                           hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Machine information registers (vendor/arch/impl/hart ID)
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr >= CsrMvendorid) && (addr <= CsrMhartid);
  endfunction

endpackage

// File: rtl/scr1_csr_alu.sv
// Combinational new-value computation for CSR read-modify-write.
// Ports:
//   op_i      - request op (RW / RS / RC)
//   old_i     - current CSR value read from the register file
//   wdata_i   - rs1 value or zero-extended zimm
//   new_o     - value to write back
module scr1_csr_alu
  import scr1_csr_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] new_o
);

  always_comb begin
    new_o = '0;
    case (op_i)
      CsrOpRw: new_o = wdata_i;
      CsrOpRs: new_o = old_i | wdata_i;
      CsrOpRc: new_o = old_i & ~wdata_i;
      default: new_o = '0;
    endcase
  end

endmodule

// File: rtl/scr1_csr_seq.sv
// CSR instruction sequencer between execute and the machine-mode CSR file.
// A CSRRW/CSRRS/CSRRC request is split into a read cycle and a write cycle to
// match the CSR file's registered read; the old value (or an illegal flag) is
// returned on a valid/ready response channel.
// Ports:
//   clk_i, rst_i                    - clock, asynchronous active-high reset
//   req_valid_i/req_ready_o         - request handshake (ready only when idle)
//   req_op_i/addr_i/wdata_i/rs1_zero_i - request payload
//   csr_addr_o/en_read_o/en_write_o/wdata_o, csr_rdata_i - CSR file port
//   rsp_valid_o/rsp_ready_i         - response handshake
//   rsp_rdata_o/rsp_illegal_o       - response payload
// Configuration:
//   SCR1_CSR_RO_CHECK_EN - when defined, writes to the read-only ID CSRs
//                          (0xF11-0xF14) are flagged illegal.
module scr1_csr_seq
  import scr1_csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_rs1_zero_i,
  output logic [31:0] csr_addr_o,
  output logic        csr_en_read_o,
  output logic        csr_en_write_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o
);

  csr_state_e  r_state;
  csr_state_e  w_state_next;
  logic [1:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rs1_zero;
  logic [31:0] r_rdata;
  logic        r_illegal;

  logic        w_accept;
  logic        w_req_illegal;
  logic        w_write_needed;
  logic [31:0] w_new_val;

  assign w_accept = req_valid_i & (r_state == StIdle);

`ifdef SCR1_CSR_RO_CHECK_EN
  logic w_req_write_needed;
  assign w_req_write_needed = (req_op_i == CsrOpRw) | ~req_rs1_zero_i;
  assign w_req_illegal = (req_op_i == CsrOpRsv) | ~csr_is_mapped(req_addr_i)
                       | (csr_is_ro(req_addr_i) & w_req_write_needed);
`else
  assign w_req_illegal = (req_op_i == CsrOpRsv) | ~csr_is_mapped(req_addr_i);
`endif

  // RS/RC with x0 / zimm=0 are pure reads and must not touch the CSR
  assign w_write_needed = (r_op == CsrOpRw) | ~r_rs1_zero;

  scr1_csr_alu u_alu (
    .op_i    (r_op),
    .old_i   (csr_rdata_i),
    .wdata_i (r_wdata),
    .new_o   (w_new_val)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_op       <= CsrOpRsv;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rs1_zero <= 1'b0;
      r_rdata    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op       <= req_op_i;
        r_addr     <= req_addr_i;
        r_wdata    <= req_wdata_i;
        r_rs1_zero <= req_rs1_zero_i;
        r_illegal  <= w_req_illegal;
        r_rdata    <= '0;
      end
      if (r_state == StWrite) begin
        r_rdata <= csr_rdata_i;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    req_ready_o    = 1'b0;
    csr_en_read_o  = 1'b0;
    csr_en_write_o = 1'b0;
    csr_wdata_o    = '0;
    rsp_valid_o    = 1'b0;
    rsp_rdata_o    = '0;
    rsp_illegal_o  = 1'b0;
    unique case (r_state)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_state_next = w_req_illegal ? StResp : StRead;
        end
      end
      StRead: begin
        csr_en_read_o = 1'b1;
        w_state_next  = StWrite;
      end
      StWrite: begin
        // Data is driven even when the write is suppressed; only the enable gates it
        csr_en_write_o = w_write_needed;
        csr_wdata_o    = w_new_val;
        w_state_next   = StResp;
      end
      StResp: begin
        rsp_valid_o   = 1'b1;
        rsp_rdata_o   = r_rdata;
        rsp_illegal_o = r_illegal;
        if (rsp_ready_i) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign csr_addr_o = {20'b0, r_addr};

endmodule

// File: tb/tb_scr1_csr_seq.sv
// Self-checking bench for scr1_csr_seq with a behavioural CSR file model
// (registered read, write priority).
module tb_scr1_csr_seq;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_rs1_zero_i;
  logic [31:0] csr_addr_o;
  logic        csr_en_read_o;
  logic        csr_en_write_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_illegal_o;

  int checks;
  int errors;

  scr1_csr_seq dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_rs1_zero_i (req_rs1_zero_i),
    .csr_addr_o     (csr_addr_o),
    .csr_en_read_o  (csr_en_read_o),
    .csr_en_write_o (csr_en_write_o),
    .csr_wdata_o    (csr_wdata_o),
    .csr_rdata_i    (csr_rdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_illegal_o  (rsp_illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model; preload port lets the bench seed values
  logic [31:0] mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (csr_en_write_o) mem[csr_addr_o[11:0]] <= csr_wdata_o;
    else if (csr_en_read_o) csr_rdata_i <= mem[csr_addr_o[11:0]];
  end

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rs1z;
    logic [31:0] prior;
    logic        ill;
    logic        wr;
    logic [31:0] nval;
    logic [31:0] final_v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                           input logic z);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_wdata_i = wd; req_rs1_zero_i = z;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    preload(v.addr, v.prior);
    @(negedge clk);
    chk({tag, ".req_ready_idle"}, 32'(req_ready_o), 32'd1);
    drive_req(v.op, v.addr, v.wdata, v.rs1z);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    if (v.ill) begin
      chk({tag, ".ill_valid"}, 32'(rsp_valid_o), 32'd1);
      chk({tag, ".ill_flag"}, 32'(rsp_illegal_o), 32'd1);
      chk({tag, ".ill_rdata"}, rsp_rdata_o, 32'd0);
      chk({tag, ".ill_en"}, {30'd0, csr_en_read_o, csr_en_write_o}, 32'd0);
    end else begin
      chk({tag, ".rd_en"}, {30'd0, csr_en_read_o, csr_en_write_o}, 32'd2);
      chk({tag, ".rd_valid"}, 32'(rsp_valid_o), 32'd0);
      chk({tag, ".rd_ready"}, 32'(req_ready_o), 32'd0);
      chk({tag, ".addr"}, csr_addr_o, {20'd0, v.addr});
      @(negedge clk);
      chk({tag, ".wr_en"}, {30'd0, csr_en_read_o, csr_en_write_o}, {31'd0, v.wr});
      chk({tag, ".wr_data"}, csr_wdata_o, v.nval);
      chk({tag, ".wr_valid"}, 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
      chk({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd1);
      chk({tag, ".rsp_ill"}, 32'(rsp_illegal_o), 32'd0);
      chk({tag, ".rsp_rdata"}, rsp_rdata_o, v.prior);
      chk({tag, ".rsp_wdata0"}, csr_wdata_o, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk({tag, ".post_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, ".post_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, ".csr_final"}, mem[v.addr], v.final_v);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, ".en"}, {30'd0, csr_en_read_o, csr_en_write_o}, 32'd0);
    chk({tag, ".addr"}, csr_addr_o, 32'd0);
    chk({tag, ".wdata"}, csr_wdata_o, 32'd0);
    chk({tag, ".rsp"}, {30'd0, rsp_valid_o, rsp_illegal_o}, 32'd0);
    chk({tag, ".rdata"}, rsp_rdata_o, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'b00; req_addr_i = '0; req_wdata_i = '0;
    req_rs1_zero_i = 1'b0; rsp_ready_i = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    //        op     addr     wdata          rs1z  prior          ill   wr    nval           final
    vecs[0] = '{2'b01, 12'h305, 32'h8000_0100, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0100,
                32'h8000_0100};
    vecs[1] = '{2'b10, 12'h304, 32'h0000_0888, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_0888,
                32'h0000_0888};
    vecs[2] = '{2'b10, 12'h304, 32'h0000_0888, 1'b1, 32'h0000_0888, 1'b0, 1'b0, 32'h0000_0888,
                32'h0000_0888};
    vecs[3] = '{2'b11, 12'h300, 32'h0000_0008, 1'b0, 32'h0000_1888, 1'b0, 1'b1, 32'h0000_1880,
                32'h0000_1880};
    vecs[4] = '{2'b01, 12'h7C0, 32'h1234_5678, 1'b0, 32'h0000_00AA, 1'b1, 1'b0, 32'h0,
                32'h0000_00AA};
    vecs[5] = '{2'b00, 12'h300, 32'h0000_0001, 1'b0, 32'h0000_0055, 1'b1, 1'b0, 32'h0,
                32'h0000_0055};
`ifdef SCR1_CSR_RO_CHECK_EN
    vecs[6] = '{2'b01, 12'hF14, 32'h0000_0055, 1'b0, 32'h0000_1234, 1'b1, 1'b0, 32'h0,
                32'h0000_1234};
`else
    vecs[6] = '{2'b01, 12'hF14, 32'h0000_0055, 1'b0, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0055,
                32'h0000_0055};
`endif
    vecs[7] = '{2'b10, 12'hF11, 32'h0000_0000, 1'b1, 32'h0000_ABCD, 1'b0, 1'b0, 32'h0000_ABCD,
                32'h0000_ABCD};
    vecs[8] = '{2'b11, 12'hB00, 32'hFFFF_0000, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_5678,
                32'h0000_5678};
    vecs[9] = '{2'b10, 12'h342, 32'h8000_0000, 1'b0, 32'h0000_000B, 1'b0, 1'b1, 32'h8000_000B,
                32'h8000_000B};

    // Reset state
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk_reset_outs("post_reset");

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Response back-pressure: hold rsp_ready low for 5 cycles
    preload(12'h341, 32'h0000_0200);
    @(negedge clk);
    drive_req(2'b01, 12'h341, 32'h0000_0100, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d.valid", c), 32'(rsp_valid_o), 32'd1);
      chk($sformatf("stall%0d.rdata", c), rsp_rdata_o, 32'h0000_0200);
      chk($sformatf("stall%0d.ready", c), 32'(req_ready_o), 32'd0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("stall.done_valid", 32'(rsp_valid_o), 32'd0);
    chk("stall.done_ready", 32'(req_ready_o), 32'd1);
    chk("stall.csr", mem[12'h341], 32'h0000_0100);

    // Reset during READ
    preload(12'h305, 32'h0000_0077);
    @(negedge clk);
    drive_req(2'b01, 12'h305, 32'h0000_DEAD, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rst_rd.in_read", 32'(csr_en_read_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk_reset_outs("rst_rd");
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd.csr", mem[12'h305], 32'h0000_0077);
    chk("rst_rd.ready", 32'(req_ready_o), 32'd1);

    // Reset during WRITE
    @(negedge clk);
    drive_req(2'b01, 12'h305, 32'h0000_BEEF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_wr.in_write", 32'(csr_en_write_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk_reset_outs("rst_wr");
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr.csr", mem[12'h305], 32'h0000_0077);
    chk_reset_outs("rst_wr.idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr1_csr_seq.md
# scr1_csr_seq

CSR instruction sequencer sitting directly upstream of the `scr1` machine-mode CSR register file. It accepts one CSRRW/CSRRS/CSRRC request at a time from execute and performs the read-modify-write as a read cycle followed by a write cycle, honouring the register file's registered read. It returns the old CSR value, or an illegal-access flag, to writeback over a valid/ready response.

## Interface
Parameters: none.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: sequencer idle; request accepted on `req_valid_i & req_ready_o`.
- `req_op_i` in 2: 01 RW, 10 RS, 11 RC, 00 reserved.
- `req_addr_i` in 12: CSR address.
- `req_wdata_i` in 32: rs1 value or zero-extended zimm.
- `req_rs1_zero_i` in 1: source is x0/zimm=0; suppresses the write for RS/RC.
- `csr_addr_o` out 32: to the CSR file, `req_addr_i` zero-extended.
- `csr_en_read_o` out 1: CSR file read enable.
- `csr_en_write_o` out 1: CSR file write enable.
- `csr_wdata_o` out 32: CSR file write data.
- `csr_rdata_i` in 32: CSR file registered read data.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response accepted.
- `rsp_rdata_o` out 32: old CSR value; 0 when illegal.
- `rsp_illegal_o` out 1: illegal CSR access.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- On accept, the sequencer latches op, addr, wdata, and rs1_zero. Illegal = op==00 OR addr not among the 16 mapped CSRs (0x300, 0x301, 0x304, 0x305, 0x306, 0x341, 0x342, 0x344, 0xB00, 0xB02, 0xB80, 0xB82, 0xF11–0xF14).
- Illegal: IDLE goes directly to RESP. No CSR enables are asserted. `rsp_rdata_o`=0 and `rsp_illegal_o`=1.
- Legal: IDLE→READ→WRITE→RESP.
  - READ: `csr_en_read_o`=1.
  - WRITE: `csr_rdata_i` is valid. The old value is captured. `csr_en_write_o` equals write_needed.
- write_needed = (op==RW) OR !rs1_zero.
- New value, 32-bit bitwise:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
- `csr_en_read_o` and `csr_en_write_o` are never high in the same cycle, because the CSR file gives write priority.
- RESP holds `rsp_valid_o` with stable rdata and illegal until `rsp_ready_i`, then returns to IDLE.
- `req_ready_o`=1 only in IDLE. Back-to-back requests are separated by at least one IDLE cycle.
- `csr_addr_o` is registered at accept and held until the next accept.
- Reset at any point: the FSM goes to IDLE and any in-flight request is dropped without a write.

## Timing
- Reset values: `req_ready_o`=1. All other outputs are 0, including `csr_addr_o`, `csr_wdata_o`, and `rsp_rdata_o`.
- Legal request accepted at edge E0:
  - Cycle E0–E1: READ.
  - E1: CSR file registers data.
  - E1–E2: WRITE, with `csr_wdata_o` driven combinationally from `csr_rdata_i` and the latched operand.
  - E2: old value captured and write committed.
  - From E2: `rsp_valid_o`=1.
- Legal latency: 2 cycles accept→`rsp_valid_o`. Earliest response handshake is at E3.
- Illegal latency: 1 cycle.
- `csr_wdata_o` is 0 outside WRITE.

## Configuration
- `SCR1_CSR_RO_CHECK_EN` defined:
  - A request to 0xF11–0xF14 with write_needed is illegal: no read, no write, `rsp_illegal_o`=1.
  - Reads of those addresses (RS/RC with rs1_zero) remain legal.
- Undefined: read-only IDs are treated as ordinary writable CSRs.

## Structure
- Package `scr1_csr_pkg` contains:
  - op encodings;
  - FSM state typedef;
  - the 16 CSR address constants;
  - functions `csr_is_mapped` and `csr_is_ro`.
- One sub-module, `scr1_csr_alu`: combinational RW/RS/RC new-value computation.

## Test plan
- CSRRW 0x305 wdata 0x8000_0100, prior mtvec 0 → READ then WRITE with `csr_wdata_o`=0x8000_0100; rsp_rdata=0, illegal=0, `rsp_valid_o` 2 cycles after accept.
- CSRRS 0x304 wdata 0x0000_0888, prior mie 0x0000_0008 → write 0x0000_0888, rsp 0x8. Repeat with `req_rs1_zero_i`=1 → `csr_en_write_o` stays 0, rsp 0x888.
- CSRRC 0x300 wdata 0x8, prior 0x1888 → write 0x1880, rsp 0x1888.
- Unmapped 0x7C0 or op=00 → no enables, rsp illegal=1, rdata=0, 1-cycle latency. With macro: CSRRW 0xF14 → illegal=1, no write. Without macro: write occurs.
- `rsp_ready_i` held low 5 cycles → `rsp_valid_o`/rdata stable, `req_ready_o`=0 until handshake.
- `rst_i` pulsed during READ and during WRITE → immediate IDLE, all outputs at reset values, CSR value unchanged by the aborted request.
